apb_slave_regfile: RTL and testbench

APB responder holding a small 32-bit register file, sitting on one `psel` line of the AHB-to-APB bridge's APB side. Decodes setup/access phases from the bridge controller, inserts a configurable number of wait states through `pready`, commits writes, returns read data and flags bad accesses with `pslverr`. The last register is a read-only count of completed transfers, used as a bench-visible activity monitor.

---
 rtl/apb_slave_regfile.sv | 106 ++++++++++
 tb/tb_apb_slave_regfile.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB responder with a small 32-bit register file, programmable wait states and a read-only
// completed-transfer counter in the last register slot.
`timescale 1ns / 1ps
module apb_slave_regfile #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int unsigned NumData  = NUM_REGS - 1;
  localparam logic [2:0]  CntIdx   = 3'(NUM_REGS - 1);
  localparam logic [3:0]  NumRegsW = 4'(NUM_REGS);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_idx;
  logic        r_write;
  logic        r_err;
  logic [31:0] r_wdata;
  logic [31:0] r_count;
  logic [31:0] r_regs [NumData];

  logic        w_setup_err;
  logic        w_pready;
  logic [31:0] w_rd;
  logic        w_unused_paddr;

  assign w_unused_paddr = ^paddr[31:5];

  // Errors are resolved at setup so the access phase only needs the latched flag.
  assign w_setup_err = (paddr[1:0] != 2'b00) | ({1'b0, paddr[4:2]} >= NumRegsW) |
                       (pwrite & (paddr[4:2] == CntIdx));

  assign w_pready = (r_state == StAccess) && (r_cnt == 4'd0);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_idx   <= 3'd0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 32'd0;
      r_count <= 32'd0;
      for (int unsigned i = 0; i < NumData; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (psel && !penable) begin
            r_idx   <= paddr[4:2];
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_err   <= w_setup_err;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= StAccess;
          end
        end
        StAccess: begin
          if (!psel) begin
            r_state <= StIdle;
          end else if (penable) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              if (r_write && !r_err) begin
                for (int unsigned i = 0; i < NumData; i++) begin
                  if (r_idx == 3'(i)) r_regs[i] <= r_wdata;
                end
              end
              r_count <= r_count + 32'd1;
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_rd = 32'd0;
    if (r_idx == CntIdx) w_rd = r_count;
    for (int unsigned i = 0; i < NumData; i++) begin
      if (r_idx == 3'(i)) w_rd = r_regs[i];
    end
  end

  assign pready  = w_pready;
  assign prdata  = (w_pready && !r_write && !r_err) ? w_rd : 32'd0;
  assign pslverr = w_pready & r_err;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: four apb_slave_regfile instances with different parameters share one
// APB bus, each on its own select bit; expectations flow through a scoreboard queue.
`timescale 1ns / 1ps
module tb_apb_slave_regfile;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] rdata_w [4];
  logic        ready_w [4];
  logic        err_w   [4];

  int tests = 0;
  int fails = 0;

  always #5 hclk = ~hclk;

  // 0: 8 regs / 0 waits, 1: 8 regs / 3 waits, 2: 8 regs / 2 waits, 3: 6 regs / 0 waits
  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rdata_w[0]), .pready(ready_w[0]), .pslverr(err_w[0])
  );
  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rdata_w[1]), .pready(ready_w[1]), .pslverr(err_w[1])
  );
  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rdata_w[2]), .pready(ready_w[2]), .pslverr(err_w[2])
  );
  apb_slave_regfile #(.NUM_REGS(6), .WAIT_STATES(0)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .psel(psel[3]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rdata_w[3]), .pready(ready_w[3]), .pslverr(err_w[3])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  typedef struct {
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[20];

  function automatic int ws_of(input int k);
    case (k)
      1: return 3;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer; with keep=1 psel stays high so the next call issues a back-to-back setup.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                      input bit keep);
    exp_t e;
    int   waits;
    bit   got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.waits = ws_of(k);
    sb.push_back(e);
    @(posedge hclk); #1;
    psel    = 4'b0000;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge hclk);
    chk("setup_pready", {31'd0, ready_w[k]}, 32'd0);
    @(posedge hclk); #1;
    penable = 1'b1;
    waits = 0;
    got   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge hclk);
      if (ready_w[k]) begin
        got = 1'b1;
        break;
      end
      chk("wait_prdata", rdata_w[k], 32'd0);
      waits++;
    end
    e = sb.pop_front();
    if (!got) begin
      chk("pready_timeout", 32'd0, 32'd1);
    end else begin
      chk("prdata", rdata_w[k], e.rdata);
      chk("pslverr", {31'd0, err_w[k]}, {31'd0, e.err});
      chk("wait_cycles", 32'(waits), 32'(e.waits));
    end
    if (!keep) begin
      @(posedge hclk); #1;
      psel    = 4'b0000;
      penable = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  got;

    // DUT 0 (8 regs): 7 transfers already done before the table
    vecs[0]  = '{0, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2]  = '{0, 1'b0, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{0, 1'b0, 32'h14, 32'h0,        32'h105,      1'b0};
    vecs[4]  = '{0, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{0, 1'b1, 32'h1C, 32'h12345678, 32'h0,        1'b1};
    vecs[6]  = '{0, 1'b0, 32'h1C, 32'h0,        32'd13,       1'b0};
    vecs[7]  = '{0, 1'b1, 32'h08, 32'hA5A50001, 32'h0,        1'b0};
    vecs[8]  = '{0, 1'b1, 32'h03, 32'h0000FFFF, 32'h0,        1'b1};
    vecs[9]  = '{0, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{0, 1'b0, 32'h08, 32'h0,        32'hA5A50001, 1'b0};
    // DUT 3 (6 regs, counter at 0x14)
    vecs[11] = '{3, 1'b1, 32'h10, 32'h1111,     32'h0,        1'b0};
    vecs[12] = '{3, 1'b1, 32'h18, 32'h2222,     32'h0,        1'b1};
    vecs[13] = '{3, 1'b0, 32'h18, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{3, 1'b0, 32'h10, 32'h0,        32'h1111,     1'b0};
    vecs[15] = '{3, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    vecs[16] = '{3, 1'b0, 32'h14, 32'h0,        32'd5,        1'b0};
    // DUT 1 (3 wait states): one read already done before the table
    vecs[17] = '{1, 1'b1, 32'h0C, 32'h77,       32'h0,        1'b0};
    vecs[18] = '{1, 1'b0, 32'h0C, 32'h0,        32'h77,       1'b0};
    vecs[19] = '{1, 1'b0, 32'h1C, 32'h0,        32'd3,        1'b0};

    hreset  = 1'b1;
    psel    = 4'b0000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    repeat (3) @(negedge hclk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_pready", {31'd0, ready_w[k]}, 32'd0);
      chk("reset_pslverr", {31'd0, err_w[k]}, 32'd0);
      chk("reset_prdata", rdata_w[k], 32'd0);
    end
    hreset = 1'b0;

    xfer(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Five back-to-back writes, then counter reads
    for (int i = 1; i <= 5; i++) begin
      xfer(0, 1'b1, 32'(i * 4), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b1);
    end
    xfer(0, 1'b0, 32'h1C, 32'h0, 32'd5, 1'b0, 1'b1);
    xfer(0, 1'b0, 32'h1C, 32'h0, 32'd6, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      xfer(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b0);
    end

    // Abort on DUT 2: drop psel in the middle of the wait states
    xfer(2, 1'b1, 32'h04, 32'h55, 32'h0, 1'b0, 1'b0);
    @(posedge hclk); #1;
    psel    = 4'b0100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h04;
    pwdata  = 32'h99;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    chk("abort_wait_pready", {31'd0, ready_w[2]}, 32'd0);
    @(posedge hclk); #1;
    psel    = 4'b0000;
    penable = 1'b0;
    @(posedge hclk); #1;
    chk("abort_idle_pready", {31'd0, ready_w[2]}, 32'd0);
    xfer(2, 1'b0, 32'h04, 32'h0, 32'h55, 1'b0, 1'b0);
    xfer(2, 1'b0, 32'h1C, 32'h0, 32'd2, 1'b0, 1'b0);

    // Async reset while DUT 1 is presenting read data
    @(posedge hclk); #1;
    psel    = 4'b0010;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0C;
    @(posedge hclk); #1;
    penable = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge hclk);
      got = ready_w[1];
      cyc++;
    end
    chk("pre_reset_prdata", rdata_w[1], 32'h77);
    #2;
    hreset = 1'b1;
    #1;
    chk("async_reset_pready", {31'd0, ready_w[1]}, 32'd0);
    chk("async_reset_prdata", rdata_w[1], 32'd0);
    chk("async_reset_pslverr", {31'd0, err_w[1]}, 32'd0);
    psel    = 4'b0000;
    penable = 1'b0;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;

    xfer(1, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b0);
    xfer(1, 1'b0, 32'h1C, 32'h0, 32'd1, 1'b0, 1'b0);
    xfer(0, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
